// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit with private HI/LO registers for the E stage.
// One result bit per cycle: MSB-first shift-add multiply, restoring divide, sign fix-up at the end.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div0_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Two's-complement negate when cond is set; used for magnitudes and sign fix-up.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic cond);
        return cond ? (-v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic cond);
        return cond ? (-v) : v;
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_x_q, sign_x_d;
    // opnd: multiplicand (mul) or divisor (div); sh: multiplier (mul) or dividend/quotient (div)
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     sh_q, sh_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 div0_q, div0_d;

    logic                 accept_s;
    logic                 in_signed_s;
    logic [WIDTH-1:0]     mag_a_s;
    logic [WIDTH-1:0]     mag_b_s;
    logic [2*WIDTH-1:0]   mul_step_s;
    logic [WIDTH:0]       trial_s;
    logic                 fits_s;
    logic [WIDTH:0]       rem_step_s;
    logic                 op_signed_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quo_res_s;
    logic [WIDTH-1:0]     rem_res_s;

    // Accept decode, operand magnitudes and the per-cycle iteration datapath.
    always_comb begin
        accept_s    = start_i & (state_q == S_IDLE) & ~done_q & ~flush_i;
        in_signed_s = ~op_i[0];
        mag_a_s     = neg_if(a_i, in_signed_s & a_i[WIDTH-1]);
        mag_b_s     = neg_if(b_i, in_signed_s & b_i[WIDTH-1]);

        mul_step_s  = {acc_q[2*WIDTH-2:0], 1'b0}
                    + (sh_q[WIDTH-1] ? {{WIDTH{1'b0}}, opnd_q} : {(2*WIDTH){1'b0}});

        trial_s     = {rem_q[WIDTH-1:0], sh_q[WIDTH-1]};
        fits_s      = (trial_s >= {1'b0, opnd_q});
        rem_step_s  = fits_s ? (trial_s - {1'b0, opnd_q}) : trial_s;

        op_signed_s = ~op_q[0];
        prod_s      = neg2_if(acc_q, op_signed_s & sign_x_q);
        quo_res_s   = neg_if(sh_q, op_signed_s & sign_x_q);
        rem_res_s   = neg_if(rem_q[WIDTH-1:0], op_signed_s & sign_a_q);
    end

    // Next-state logic: FSM, iteration registers and HI/LO update (FIX result beats MTHI/MTLO).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_x_d = sign_x_q;
        opnd_d   = opnd_q;
        sh_d     = sh_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        hi_d     = hi_we_i ? wdata_i : hi_q;
        lo_d     = lo_we_i ? wdata_i : lo_q;
        done_d   = 1'b0;
        div0_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d  = S_CALC;
                    cnt_d    = {CNT_W{1'b0}};
                    op_d     = op_i;
                    sign_a_d = a_i[WIDTH-1];
                    sign_x_d = a_i[WIDTH-1] ^ b_i[WIDTH-1];
                    opnd_d   = op_i[1] ? mag_b_s : mag_a_s;
                    sh_d     = op_i[1] ? mag_a_s : mag_b_s;
                    acc_d    = {(2*WIDTH){1'b0}};
                    rem_d    = {(WIDTH+1){1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q[1]) begin
                        rem_d = rem_step_s;
                        sh_d  = {sh_q[WIDTH-2:0], fits_s};
                    end else begin
                        acc_d = mul_step_s;
                        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush_i) begin
                    done_d = 1'b1;
                    if (op_q[1]) begin
                        // Divisor magnitude is zero exactly when the raw divisor was zero.
                        if (opnd_q == {WIDTH{1'b0}}) begin
                            div0_d = 1'b1;
                        end else begin
                            hi_d = rem_res_s;
                            lo_d = quo_res_s;
                        end
                    end else begin
                        hi_d = prod_s[2*WIDTH-1:WIDTH];
                        lo_d = prod_s[WIDTH-1:0];
                    end
                end else begin
                    done_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            op_q     <= 2'b00;
            sign_a_q <= 1'b0;
            sign_x_q <= 1'b0;
            opnd_q   <= {WIDTH{1'b0}};
            sh_q     <= {WIDTH{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            rem_q    <= {(WIDTH+1){1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_x_q <= sign_x_d;
            opnd_q   <= opnd_d;
            sh_q     <= sh_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
        end
    end

    // Stall request must be combinational so the accept cycle itself freezes the pipe.
    assign busy_o = (state_q != S_IDLE) | accept_s;
    assign done_o = done_q;
    assign div0_o = div0_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit (WIDTH=32) against a 64-bit arithmetic reference.
module tb_muldiv_hilo_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        flush_i, hi_we_i, lo_we_i;
    logic [31:0] wdata_i;
    logic        busy_o, done_o, div0_o;
    logic [31:0] hi_o, lo_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] hi_m, lo_m;

    muldiv_hilo_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .done_o(done_o), .div0_o(div0_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    // Architectural result of one op; HI/LO untouched on divide by zero.
    task automatic ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          inout logic [31:0] hi, inout logic [31:0] lo, output logic d0);
        longint      p, q, r;
        logic [63:0] u;
        d0 = 1'b0;
        case (op)
            2'd0: begin p = longint'($signed(a)) * longint'($signed(b)); u = p; hi = u[63:32]; lo = u[31:0]; end
            2'd1: begin u = {32'd0, a} * {32'd0, b}; hi = u[63:32]; lo = u[31:0]; end
            2'd2: begin
                if (b == 32'd0) d0 = 1'b1;
                else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    u = q; lo = u[31:0];
                    u = r; hi = u[31:0];
                end
            end
            default: begin
                if (b == 32'd0) d0 = 1'b1;
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endtask

    // Issue one op and wait (bounded) for done_o; returns at the negedge of the done cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, output int bcnt, output bit got_done, output bit got_d0);
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        bcnt = 0; got_done = 1'b0; got_d0 = 1'b0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (busy_o) bcnt++;
            @(negedge clk);
            if (!hold) start_i = 1'b0;
            if (done_o) begin got_done = 1'b1; got_d0 = div0_o; break; end
        end
    endtask

    task automatic mt_write(input bit hw, input bit lw, input logic [31:0] d);
        @(negedge clk);
        hi_we_i = hw; lo_we_i = lw; wdata_i = d;
        @(negedge clk);
        hi_we_i = 1'b0; lo_we_i = 1'b0;
        if (hw) hi_m = d;
        if (lw) lo_m = d;
    endtask

    task automatic test_reset();
        #12;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        total++; if (done_o !== 1'b0 || div0_o !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", done_o, div0_o); end
        total++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin bad++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi_o, lo_o); end
        @(negedge clk); rst = 1'b1;
        hi_m = 32'd0; lo_m = 32'd0;
    endtask

    task automatic test_multu_max();
        int bc; bit gd, g0;
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, bc, gd, g0);
        #1;
        total++; if (bc !== 34) begin bad++; $display("FAIL multu_busy_cycles got=%0d exp=34", bc); end
        total++; if (!gd) begin bad++; $display("FAIL multu_done got=0 exp=1"); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL multu_busy_at_done got=%b exp=0", busy_o); end
        total++; if (hi_o !== 32'hFFFF_FFFE || lo_o !== 32'h0000_0001) begin bad++; $display("FAIL multu_max got=%h/%h exp=fffffffe/00000001", hi_o, lo_o); end
        @(negedge clk);
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b exp=0", done_o); end
        hi_m = 32'hFFFF_FFFE; lo_m = 32'h0000_0001;
    endtask

    task automatic test_signed();
        int bc; bit gd, g0;
        run_op(2'd0, -32'sd3, 32'sd5, 1'b0, bc, gd, g0);
        total++; if (!gd || hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mult_neg got=%b %h/%h exp=1 ffffffff/fffffff1", gd, hi_o, lo_o); end
        run_op(2'd2, -32'sd7, 32'sd2, 1'b0, bc, gd, g0);
        total++; if (!gd || g0 || hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg got=%b%b %h/%h exp=10 ffffffff/fffffffd", gd, g0, hi_o, lo_o); end
        hi_m = 32'hFFFF_FFFF; lo_m = 32'hFFFF_FFFD;
    endtask

    task automatic test_div0();
        int bc; bit gd, g0;
        mt_write(1'b1, 1'b0, 32'h0000_1234);
        mt_write(1'b0, 1'b1, 32'h0000_5678);
        total++; if (hi_o !== 32'h1234 || lo_o !== 32'h5678) begin bad++; $display("FAIL mthi_mtlo got=%h/%h exp=1234/5678", hi_o, lo_o); end
        run_op(2'd3, 32'd100, 32'd0, 1'b0, bc, gd, g0);
        total++; if (bc !== 34 || !gd) begin bad++; $display("FAIL div0_latency got=%0d,%b exp=34,1", bc, gd); end
        total++; if (g0 !== 1'b1) begin bad++; $display("FAIL div0_flag got=%b exp=1", g0); end
        total++; if (hi_o !== 32'h1234 || lo_o !== 32'h5678) begin bad++; $display("FAIL div0_hilo got=%h/%h exp=1234/5678", hi_o, lo_o); end
        @(negedge clk);
        total++; if (div0_o !== 1'b0) begin bad++; $display("FAIL div0_one_cycle got=%b exp=0", div0_o); end
    endtask

    task automatic test_flush();
        int bc; bit gd, g0; int dones;
        @(negedge clk);
        start_i = 1'b1; op_i = 2'd1; a_i = 32'd7; b_i = 32'd6;
        for (int k = 1; k < 10; k++) begin @(negedge clk); start_i = 1'b0; end
        @(negedge clk); flush_i = 1'b1;
        #1;
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL flush_busy_before got=%b exp=1", busy_o); end
        @(negedge clk); flush_i = 1'b0;
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL flush_busy_drop got=%b exp=0", busy_o); end
        dones = 0;
        for (int k = 0; k < 40; k++) begin @(negedge clk); if (done_o) dones++; end
        total++; if (dones !== 0) begin bad++; $display("FAIL flush_no_done got=%0d exp=0", dones); end
        total++; if (hi_o !== hi_m || lo_o !== lo_m) begin bad++; $display("FAIL flush_hilo got=%h/%h exp=%h/%h", hi_o, lo_o, hi_m, lo_m); end
        run_op(2'd1, 32'd7, 32'd6, 1'b0, bc, gd, g0);
        total++; if (bc !== 34 || !gd || hi_o !== 32'd0 || lo_o !== 32'd42) begin bad++; $display("FAIL after_flush got=%0d,%b %h/%h exp=34,1 0/2a", bc, gd, hi_o, lo_o); end
        hi_m = 32'd0; lo_m = 32'd42;
    endtask

    task automatic test_overflow_hold();
        int bc; bit gd, g0; int dones;
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, bc, gd, g0);
        #1;
        total++; if (!gd || g0 || lo_o !== 32'h8000_0000 || hi_o !== 32'd0) begin bad++; $display("FAIL div_overflow got=%b%b %h/%h exp=10 0/80000000", gd, g0, hi_o, lo_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL start_held_done_busy got=%b exp=0", busy_o); end
        @(negedge clk); start_i = 1'b0;
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL no_reissue_busy got=%b exp=0", busy_o); end
        dones = 0;
        for (int k = 0; k < 40; k++) begin @(negedge clk); if (done_o) dones++; end
        total++; if (dones !== 0) begin bad++; $display("FAIL no_reissue_done got=%0d exp=0", dones); end
        hi_m = 32'd0; lo_m = 32'h8000_0000;
    endtask

    task automatic test_mt_during_op();
        int bc; bit gd, g0; logic [31:0] eh, el; logic ed;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        @(negedge clk);
        hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = $urandom;
        run_op(2'd1, a, b, 1'b0, bc, gd, g0);
        hi_we_i = 1'b0; lo_we_i = 1'b0;
        eh = 32'd0; el = 32'd0;
        ref_op(2'd1, a, b, eh, el, ed);
        total++; if (!gd || hi_o !== eh || lo_o !== el) begin bad++; $display("FAIL fix_beats_mt got=%b %h/%h exp=1 %h/%h", gd, hi_o, lo_o, eh, el); end
        hi_m = eh; lo_m = el;
    endtask

    task automatic test_random_back_to_back();
        int bc; bit gd, g0; logic ed;
        logic [1:0]  op;
        logic [31:0] a, b;
        mt_write(1'b1, 1'b1, 32'hC0DE_F00D);
        for (int n = 0; n < 30; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3:       begin a = 32'($urandom_range(0, 100)); b = -32'($urandom_range(1, 9)); end
                default: b = $urandom;
            endcase
            ref_op(op, a, b, hi_m, lo_m, ed);
            run_op(op, a, b, 1'b0, bc, gd, g0);
            total++;
            if (bc !== 34 || !gd || g0 !== ed || hi_o !== hi_m || lo_o !== lo_m) begin
                bad++;
                $display("FAIL rand[%0d] op=%0d a=%h b=%h got=%0d,%b,%b %h/%h exp=34,1,%b %h/%h",
                         n, op, a, b, bc, gd, g0, hi_o, lo_o, ed, hi_m, lo_m);
            end
        end
    endtask

    task automatic test_async_reset();
        int bc; bit gd, g0;
        mt_write(1'b1, 1'b1, 32'hA5A5_5A5A);
        @(negedge clk);
        start_i = 1'b1; op_i = 2'd3; a_i = 32'd1000; b_i = 32'd7;
        for (int k = 1; k <= 20; k++) begin @(negedge clk); start_i = 1'b0; end
        #2 rst = 1'b0;
        #1;
        total++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin bad++; $display("FAIL async_rst_hilo got=%h/%h exp=0/0", hi_o, lo_o); end
        total++; if (busy_o !== 1'b0 || done_o !== 1'b0 || div0_o !== 1'b0) begin bad++; $display("FAIL async_rst_flags got=%b%b%b exp=000", busy_o, done_o, div0_o); end
        @(negedge clk); rst = 1'b1;
        run_op(2'd3, 32'd1000, 32'd7, 1'b0, bc, gd, g0);
        total++; if (bc !== 34 || !gd || hi_o !== 32'd6 || lo_o !== 32'd142) begin bad++; $display("FAIL after_rst_op got=%0d,%b %h/%h exp=34,1 6/8e", bc, gd, hi_o, lo_o); end
    endtask

    initial begin
        rst = 1'b0; start_i = 1'b0; op_i = 2'd0; a_i = 32'd0; b_i = 32'd0;
        flush_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0; wdata_i = 32'd0;
        test_reset();
        test_multu_max();
        test_signed();
        test_div0();
        test_flush();
        test_overflow_hold();
        test_mt_during_op();
        test_random_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo_unit.md
# muldiv_hilo_unit

Parametrised iterative multiply/divide unit with its own HI/LO register pair, for the execute stage of the MIPS pipeline. It executes MULT/MULTU/DIV/DIVU in a fixed number of cycles and holds a combinational stall request so the controller can freeze the fetch, decode and execute stages. It accepts MTHI/MTLO writes and a pipeline flush, and replaces the single-cycle HI/LO path with one that scales to any operand width.

## Interface
- WIDTH, 32, operand/HI/LO width; must be ≥ 2.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- start_i  in  1  E-stage mult/div instruction present
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i
- a_i  in  WIDTH  rs operand (multiplicand / dividend)
- b_i  in  WIDTH  rt operand (multiplier / divisor)
- flush_i  in  1  cancel the in-flight op (flushE)
- hi_we_i  in  1  MTHI write enable
- lo_we_i  in  1  MTLO write enable
- wdata_i  in  WIDTH  MTHI/MTLO data
- busy_o  out  1  stall request, combinational
- done_o  out  1  one-cycle completion pulse, registered
- div0_o  out  1  divide-by-zero flag, pulses with done_o
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register

## Operation
- FSM states: IDLE, CALC, FIX. Reset (rst=0): state IDLE; counter, HI, LO, done_o, div0_o and all datapath registers are 0.
- Accept: start_i=1, state IDLE, done_o=0, flush_i=0. On that edge:
  - latch op.
  - latch |a| and |b|. Magnitudes are taken for signed ops only; unsigned ops latch raw values.
  - latch the sign of a and the sign of a XOR the sign of b.
  - counter := 0; go to CALC.
- CALC: one iteration per cycle, MSB-first.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring; WIDTH+1-bit partial remainder, one quotient bit per cycle.
  - When counter = WIDTH-1, go to FIX on that edge; otherwise counter += 1.
- FIX edge (always back to IDLE):
  - Signed multiply: negate the 2·WIDTH product if the signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Write HI := upper product / remainder and LO := lower product / quotient.
  - Set done_o=1 and div0_o = (divide && b was 0).
- Divide by zero: full latency, HI/LO unchanged, div0_o=1.
- Signed overflow: DIV of −2^(WIDTH−1) by −1 gives LO = 2^(WIDTH−1) bit pattern, HI = 0.
- busy_o = (state≠IDLE) | (start_i & state==IDLE & ~done_o & ~flush_i).
- start_i is ignored while done_o=1. This keeps the just-completed instruction, still in E during the done cycle, from re-issuing.
- flush_i=1 in CALC or FIX: go to IDLE at the next edge, no HI/LO write, no done_o. flush_i with start_i in IDLE: no accept.
- MTHI/MTLO: the write takes effect at the edge where the enable is high.
  - If it coincides with the FIX edge, the FIX result wins.
  - Writes during CALC are applied, then overwritten at FIX.
- Reset asserted mid-operation: immediate return to the reset values; the operation is lost.

## Timing
- Accept edge = E0. CALC covers edges E1..EWIDTH. The FIX edge is E(WIDTH+1).
- busy_o is high from the accept cycle through the FIX cycle: WIDTH+2 cycles.
- done_o, div0_o and the new hi_o/lo_o are visible in the cycle after the FIX edge; busy_o is 0 in that cycle.
- done_o and div0_o are high for exactly one cycle.
- hi_o/lo_o are direct register outputs: no combinational path from any input.
- Back-to-back ops: the next accept can occur one cycle after done_o, i.e. 1 idle cycle between ops.

## Test plan
- WIDTH=32. Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF.
  - busy_o high for 34 cycles, then done_o pulses.
  - hi_o=0xFFFFFFFE, lo_o=0x00000001.
- MULT a=−3 b=5 → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1. Then DIV a=−7 b=2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- MTHI 0x1234, MTLO 0x5678; then DIVU a=100 b=0.
  - done_o=1 and div0_o=1 at cycle 34.
  - HI/LO stay 0x1234/0x5678.
- MULTU a=7 b=6 with flush_i pulsed at cycle 10.
  - busy_o drops at cycle 11.
  - done_o never pulses; HI/LO unchanged.
  - A new start_i is accepted on the next cycle.
- DIV a=0x80000000 b=0xFFFFFFFF → lo_o=0x80000000, hi_o=0. start_i held high through the done cycle → no second operation starts.
- rst driven low at cycle 20 of a DIVU: all outputs 0 asynchronously; after release, an idle unit accepts a fresh op.
